pad_frame_mux: RTL and testbench



---
 rtl/pad_frame_pkg.sv | 15 +
 rtl/pad_frame_mux_if.sv | 28 ++
 rtl/reset_sync.sv | 19 +
 rtl/pad_frame_mux.sv | 136 +++++++++++++
 tb/tb_pad_frame_mux.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pad_frame_pkg.sv
// Shared types and helpers for the pad frame multiplexer.
package pad_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } fsm_state_e;

    // Index width for n items, never below one bit so that single-value counters stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pad_frame_mux_if.sv
// Core-side inputs and pad-side outputs of the frame multiplexer.
interface pad_frame_mux_if #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 4,
    parameter int CNT_W    = 16,
    parameter int CH_IDX_W = pad_frame_pkg::clog2_min1(NUM_CH)
);
    logic                     en;
    logic                     mode;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [DATA_W-1:0]        pad_data;
    logic [CH_IDX_W-1:0]      pad_sel;
    logic                     pad_frame;
    logic                     pad_valid;
    logic [CNT_W-1:0]         frame_cnt;

    // Core side: supplies channel data and control, observes the pads.
    modport master (
        output en, mode, ch_data,
        input  pad_data, pad_sel, pad_frame, pad_valid, frame_cnt
    );

    // Multiplexer side.
    modport slave (
        input  en, mode, ch_data,
        output pad_data, pad_sel, pad_frame, pad_valid, frame_cnt
    );
endinterface

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clock edge.
module reset_sync (
    input  logic clk,
    input  logic arst_n_i,
    output logic rst_n_o
);
    logic [1:0] sync_q;

    // Shift a one in after reset release; clear both flops immediately on assertion.
    always_ff @(posedge clk or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_n_o = sync_q[1];
endmodule

// File: rtl/pad_frame_mux.sv
// Time-multiplexes NUM_CH channel words onto one pad group, one frame per snapshot.
// Pad outputs are registered, so a beat computed in a SCAN cycle shows on the pads one edge later.
module pad_frame_mux
    import pad_frame_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 4,
    parameter int HOLD_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    pad_frame_mux_if.slave bus
);
    localparam int CH_IDX_W = clog2_min1(NUM_CH);
    localparam int HOLD_W   = clog2_min1(HOLD_CYC);

    logic                     rst_n;
    fsm_state_e               state_q, state_d;
    logic [NUM_CH*DATA_W-1:0] shadow_q, shadow_d;
    logic [CH_IDX_W-1:0]      ch_cnt_q, ch_cnt_d;
    logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0]        pad_data_q, pad_data_d;
    logic [CH_IDX_W-1:0]      pad_sel_q, pad_sel_d;
    logic                     pad_frame_q, pad_frame_d;
    logic                     pad_valid_q, pad_valid_d;
    logic [DATA_W-1:0]        beat;
    logic                     hold_last;
    logic                     ch_last;
    logic                     live_diff;

    reset_sync u_reset_sync (
        .clk      (clk),
        .arst_n_i (reset_n),
        .rst_n_o  (rst_n)
    );

    assign beat      = shadow_q[int'(ch_cnt_q)*DATA_W +: DATA_W];
    assign hold_last = (hold_cnt_q == HOLD_W'(HOLD_CYC - 1));
    assign ch_last   = (ch_cnt_q == CH_IDX_W'(NUM_CH - 1));
    assign live_diff = (bus.ch_data != shadow_q);

    // Next-state logic: frame sequencing, snapshot capture and pad output values.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        ch_cnt_d    = ch_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pad_data_d  = pad_data_q;
        pad_sel_d   = '0;
        pad_frame_d = 1'b0;
        pad_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    shadow_d   = bus.ch_data;
                    ch_cnt_d   = '0;
                    hold_cnt_d = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                pad_data_d  = beat;
                pad_sel_d   = ch_cnt_q;
                pad_frame_d = (ch_cnt_q == '0);
                pad_valid_d = 1'b1;
                if (!hold_last) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else begin
                    hold_cnt_d = '0;
                    if (!ch_last) begin
                        ch_cnt_d = ch_cnt_q + 1'b1;
                    end else begin
                        // Last beat of the frame: count it, then decide whether another follows.
                        ch_cnt_d    = '0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        if (!bus.en) begin
                            state_d = IDLE;
                        end else if (!bus.mode || live_diff) begin
                            shadow_d = bus.ch_data;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (live_diff) begin
                    shadow_d   = bus.ch_data;
                    ch_cnt_d   = '0;
                    hold_cnt_d = '0;
                    state_d    = SCAN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, snapshot and pad registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            ch_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            frame_cnt_q <= '0;
            pad_data_q  <= '0;
            pad_sel_q   <= '0;
            pad_frame_q <= 1'b0;
            pad_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            ch_cnt_q    <= ch_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pad_data_q  <= pad_data_d;
            pad_sel_q   <= pad_sel_d;
            pad_frame_q <= pad_frame_d;
            pad_valid_q <= pad_valid_d;
        end
    end

    assign bus.pad_data  = pad_data_q;
    assign bus.pad_sel   = pad_sel_q;
    assign bus.pad_frame = pad_frame_q;
    assign bus.pad_valid = pad_valid_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_pad_frame_mux.sv
// Scoreboard bench for pad_frame_mux with NUM_CH=4, DATA_W=4, HOLD_CYC=2.
`timescale 1ns/1ps
module tb_pad_frame_mux;
    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 4;
    localparam int HOLD_CYC = 2;
    localparam int CNT_W    = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pad_frame_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    pad_frame_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Beat word: {pad_data, pad_sel, pad_frame}
    typedef logic [6:0] beat_t;
    beat_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void push_frame(input logic [15:0] snap);
        for (int c = 0; c < NUM_CH; c++)
            for (int h = 0; h < HOLD_CYC; h++)
                exp_q.push_back({snap[c*DATA_W +: DATA_W], 2'(c), (c == 0)});
    endfunction

    function automatic beat_t act_beat();
        return {bus.pad_data, bus.pad_sel, bus.pad_frame};
    endfunction

    task automatic test_reset();
        beat_t exp;
        reset_n = 1'b1;
        bus.en = 1'b1; bus.mode = 1'b0; bus.ch_data = 16'h4321;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.pad_data, bus.pad_sel, bus.pad_frame, bus.pad_valid, bus.frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h sel=%h frame=%b valid=%b cnt=%h, required all 0",
                     bus.pad_data, bus.pad_sel, bus.pad_frame, bus.pad_valid, bus.frame_cnt);
        end
        reset_n = 1'b1;
        push_frame(16'h4321);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pad_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL release_latency cycle %0d: got valid=%b, required 0", i, bus.pad_valid);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({bus.pad_valid, bus.pad_frame, bus.pad_sel} !== 4'b1100) begin
            n_fail++;
            $display("FAIL first_beat_flags: got valid=%b frame=%b sel=%h, required 1 1 0",
                     bus.pad_valid, bus.pad_frame, bus.pad_sel);
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (act_beat() !== exp) begin
            n_fail++;
            $display("FAIL first_beat: got %h, required %h", act_beat(), exp);
        end
    endtask

    task automatic test_continuous();
        beat_t exp;
        repeat (3) push_frame(16'h4321);
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pad_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cont_gap cycle %0d: got valid=%b queued=%0d, required valid=1", i, bus.pad_valid, exp_q.size());
            end else begin
                exp = exp_q.pop_front();
                if (act_beat() !== exp) begin
                    n_fail++;
                    $display("FAIL cont_beat cycle %0d: got %h, required %h", i, act_beat(), exp);
                end
            end
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL cont_frame_cnt: got %0d, required 4", bus.frame_cnt);
        end
    endtask

    task automatic test_snapshot();
        beat_t exp;
        push_frame(16'h4321);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pad_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL snap_gap cycle %0d: got valid=%b queued=%0d, required valid=1", i, bus.pad_valid, exp_q.size());
            end else begin
                exp = exp_q.pop_front();
                if (act_beat() !== exp) begin
                    n_fail++;
                    $display("FAIL snap_beat cycle %0d: got %h, required %h", i, act_beat(), exp);
                end
            end
            if (i == 2) begin
                bus.ch_data = 16'hFFFF;
                push_frame(16'hFFFF);
            end
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL snap_frame_cnt: got %0d, required 6", bus.frame_cnt);
        end
    endtask

    task automatic test_mode_wait();
        beat_t exp;
        bus.mode = 1'b1;
        push_frame(16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pad_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wait_pre_gap cycle %0d: got valid=%b, required 1", i, bus.pad_valid);
            end else begin
                exp = exp_q.pop_front();
                if (act_beat() !== exp) begin
                    n_fail++;
                    $display("FAIL wait_pre_beat cycle %0d: got %h, required %h", i, act_beat(), exp);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.pad_valid, bus.pad_frame, bus.pad_sel, bus.pad_data, bus.frame_cnt} !== {1'b0, 1'b0, 2'd0, 4'hF, 16'd7}) begin
                n_fail++;
                $display("FAIL wait_hold cycle %0d: got valid=%b frame=%b sel=%h data=%h cnt=%0d, required 0 0 0 f 7",
                         i, bus.pad_valid, bus.pad_frame, bus.pad_sel, bus.pad_data, bus.frame_cnt);
            end
        end
        bus.ch_data = 16'hF0FF;
        push_frame(16'hF0FF);
        @(negedge clk);
        n_tests++;
        if (bus.pad_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_capture_edge: got valid=%b, required 0", bus.pad_valid);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pad_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wait_resume_gap cycle %0d: got valid=%b, required 1", i, bus.pad_valid);
            end else begin
                exp = exp_q.pop_front();
                if (act_beat() !== exp) begin
                    n_fail++;
                    $display("FAIL wait_resume_beat cycle %0d: got %h, required %h", i, act_beat(), exp);
                end
            end
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL wait_frame_cnt: got %0d, required 8", bus.frame_cnt);
        end
    endtask

    task automatic test_en_drop();
        beat_t exp;
        bus.ch_data = 16'h8765;
        push_frame(16'h8765);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pad_valid !== (i != 0)) begin
                n_fail++;
                $display("FAIL endrop_valid cycle %0d: got %b, required %b", i, bus.pad_valid, (i != 0));
            end else if (bus.pad_valid) begin
                exp = exp_q.pop_front();
                if (act_beat() !== exp) begin
                    n_fail++;
                    $display("FAIL endrop_beat cycle %0d: got %h, required %h", i, act_beat(), exp);
                end
            end
            if (i == 3) bus.en = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.pad_valid, bus.pad_frame, bus.pad_sel, bus.frame_cnt} !== {1'b0, 1'b0, 2'd0, 16'd9}) begin
                n_fail++;
                $display("FAIL endrop_idle cycle %0d: got valid=%b frame=%b sel=%h cnt=%0d, required 0 0 0 9",
                         i, bus.pad_valid, bus.pad_frame, bus.pad_sel, bus.frame_cnt);
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL endrop_leftover: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midframe_and_wrap();
        beat_t exp;
        bit    seen_ch2;
        bus.en = 1'b1; bus.mode = 1'b0; bus.ch_data = 16'hA5C3;
        push_frame(16'hA5C3);
        seen_ch2 = 1'b0;
        for (int i = 0; i < 12 && !seen_ch2; i++) begin
            @(negedge clk);
            if (bus.pad_valid) begin
                n_tests++;
                exp = exp_q.pop_front();
                if (act_beat() !== exp) begin
                    n_fail++;
                    $display("FAIL abort_beat cycle %0d: got %h, required %h", i, act_beat(), exp);
                end
                if (bus.pad_sel == 2'd2) seen_ch2 = 1'b1;
            end
        end
        n_tests++;
        if (!seen_ch2) begin
            n_fail++;
            $display("FAIL abort_reach_ch2: got no channel-2 beat, required one within 12 cycles");
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.pad_data, bus.pad_sel, bus.pad_frame, bus.pad_valid, bus.frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL abort_async: got data=%h sel=%h frame=%b valid=%b cnt=%h, required all 0",
                     bus.pad_data, bus.pad_sel, bus.pad_frame, bus.pad_valid, bus.frame_cnt);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.pad_valid, bus.frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL abort_held: got valid=%b cnt=%h, required 0 0", bus.pad_valid, bus.frame_cnt);
        end
        bus.ch_data = 16'h4321;
        reset_n = 1'b1;
        push_frame(16'h4321);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pad_valid !== (i >= 3)) begin
                n_fail++;
                $display("FAIL wrap_valid cycle %0d: got %b, required %b", i, bus.pad_valid, (i >= 3));
            end else if (bus.pad_valid) begin
                exp = exp_q.pop_front();
                if (act_beat() !== exp) begin
                    n_fail++;
                    $display("FAIL wrap_beat cycle %0d: got %h, required %h", i, act_beat(), exp);
                end
            end
            if (i == 4) force dut.frame_cnt_q = 16'hFFFF;
            if (i == 5) release dut.frame_cnt_q;
            if (i == 6) begin
                n_tests++;
                if (bus.frame_cnt !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL wrap_preload: got %h, required ffff", bus.frame_cnt);
                end
            end
        end
        n_tests++;
        if (bus.frame_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got %h, required 0000", bus.frame_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_continuous();
        test_snapshot();
        test_mode_wait();
        test_en_drop();
        test_reset_midframe_and_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
